// File: rtl/rv_bus_pkg.sv
// Shared bus types for the rv core memory path: access sizes, arbiter
// states, requester identity and the size-to-last-byte-index helper.
package rv_bus_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        ACK  = 2'b10
    } arb_state_t;

    typedef enum logic {
        IF  = 1'b0,
        LSU = 1'b1
    } owner_t;

    // A fetch is always a full word, so its last byte index is 3.
    localparam logic [1:0] FETCH_LAST_IDX = 2'd3;

    // Index of the final byte of an access: byte -> 0, half -> 1, word -> 3.
    // The unused 2'b11 encoding is treated as a word.
    function automatic logic [1:0] last_index(input logic [1:0] size);
        logic [1:0] idx;
        case (size_t'(size))
            BYTE:    idx = 2'd0;
            HALF:    idx = 2'd1;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rv_mem_arbiter.sv
// Arbitrates the fetch unit and the LSU onto one byte-wide memory port.
// A granted access is serialized little-endian, one byte per cycle, and
// completed with a one-cycle ack carrying the assembled, zero-extended data.
module rv_mem_arbiter
    import rv_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter bit          FAIR   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,

    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [1:0]        lsu_size,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_ack,
    output logic [31:0]       lsu_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,

    output logic              busy
);

    arb_state_t        state_q;
    owner_t            owner_q;
    owner_t            last_q;
    logic [ADDR_W-1:0] base_q;
    logic              we_q;
    logic [1:0]        last_idx_q;
    logic [1:0]        k_q;
    logic [31:0]       wdata_q;
    logic [31:0]       buf_q;
    logic [31:0]       buf_d;
    logic [31:0]       if_rdata_q;
    logic [31:0]       lsu_rdata_q;
    logic              grant_lsu;

    // Pick the winner for the IDLE cycle: a lone requester wins outright,
    // a tie goes to the requester not served last (FAIR) or to the LSU.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant_lsu = 1'b0;
        if (lsu_req && !if_req) begin
            grant_lsu = 1'b1;
        end else if (lsu_req && if_req) begin
            grant_lsu = FAIR ? (last_q == IF) : 1'b1;
        end
    end

    // Merge the byte arriving this cycle into its lane of the read buffer.
    always_comb begin
        buf_d = buf_q;
        if (!we_q) begin
            buf_d[{k_q, 3'b000} +: 8] = mem_rdata;
        end
    end

    // Arbiter FSM: latch the granted request, step through its bytes,
    // then spend one cycle acknowledging before returning to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the data registers are reset as well as the control
            // state, because rdata outputs must read 0 out of reset.
            state_q     <= IDLE;
            owner_q     <= IF;
            last_q      <= LSU;
            base_q      <= '0;
            we_q        <= 1'b0;
            last_idx_q  <= 2'd0;
            k_q         <= 2'd0;
            wdata_q     <= '0;
            buf_q       <= '0;
            if_rdata_q  <= '0;
            lsu_rdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            unique case (state_q)
                IDLE: begin
                    if (if_req || lsu_req) begin
                        owner_q    <= grant_lsu ? LSU : IF;
                        base_q     <= grant_lsu ? lsu_addr : if_addr;
                        we_q       <= grant_lsu && lsu_we;
                        last_idx_q <= grant_lsu ? last_index(lsu_size) : FETCH_LAST_IDX;
                        wdata_q    <= grant_lsu ? lsu_wdata : '0;
                        k_q        <= 2'd0;
                        buf_q      <= '0;
                        state_q    <= XFER;
                    end
                end
                XFER: begin
                    buf_q <= buf_d;
                    if (k_q == last_idx_q) begin
                        state_q <= ACK;
                        // Loads publish the finished buffer so it is valid
                        // during the ack cycle; stores leave rdata alone.
                        if (!we_q) begin
                            if (owner_q == IF) begin
                                if_rdata_q <= buf_d;
                            end else begin
                                lsu_rdata_q <= buf_d;
                            end
                        end
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                ACK: begin
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory port and acks decode straight from state registers, so an
    // asynchronous reset drops them immediately.
    assign busy      = (state_q != IDLE);
    assign mem_en    = (state_q == XFER);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_en ? (base_q + ADDR_W'(k_q)) : '0;
    assign mem_wdata = mem_en ? wdata_q[{k_q, 3'b000} +: 8] : 8'h00;

    assign if_ack    = (state_q == ACK) && (owner_q == IF);
    assign lsu_ack   = (state_q == ACK) && (owner_q == LSU);
    assign if_rdata  = if_rdata_q;
    assign lsu_rdata = lsu_rdata_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: directed cases plus random
// single transactions against a byte-array reference model; a second
// instance with FAIR=0 checks the LSU-priority tie policy.
module tb_rv_mem_arbiter;
    import rv_bus_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // FAIR=1 instance
    logic        if_req, if_ack, lsu_req, lsu_we, lsu_ack;
    logic [31:0] if_addr, if_rdata, lsu_addr, lsu_wdata, lsu_rdata, mem_addr;
    logic [1:0]  lsu_size;
    logic        mem_en, mem_we, busy;
    logic [7:0]  mem_wdata, mem_rdata;

    // FAIR=0 instance
    logic        z_if_req, z_if_ack, z_lsu_req, z_lsu_ack, z_mem_en, z_mem_we, z_busy;
    logic [31:0] z_if_rdata, z_lsu_rdata, z_mem_addr;
    logic [7:0]  z_mem_wdata, z_mem_rdata;

    // 256-byte memory aliased on the low address byte; exp_mem is the model.
    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];
    assign mem_rdata   = mem[mem_addr[7:0]];
    assign z_mem_rdata = z_mem_addr[7:0];

    int          vectors = 0;
    int          miscompares = 0;
    int          en_cycles;
    owner_t      model_last;
    logic [31:0] exp_if_rd, exp_lsu_rd;

    rv_mem_arbiter #(.ADDR_W(32), .FAIR(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_ack(lsu_ack), .lsu_rdata(lsu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    rv_mem_arbiter #(.ADDR_W(32), .FAIR(1'b0)) u_dut_nofair (
        .clk(clk), .rst(rst),
        .if_req(z_if_req), .if_addr(32'h0000_0000), .if_ack(z_if_ack), .if_rdata(z_if_rdata),
        .lsu_req(z_lsu_req), .lsu_we(1'b0), .lsu_size(2'b10), .lsu_addr(32'h0000_0004),
        .lsu_wdata(32'h0), .lsu_ack(z_lsu_ack), .lsu_rdata(z_lsu_rdata),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_rdata(z_mem_rdata), .busy(z_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: memory writes requested this cycle land just after the edge.
    task automatic step();
        logic       w;
        logic [7:0] a, d;
        w = mem_en && mem_we;
        a = mem_addr[7:0];
        d = mem_wdata;
        en_cycles += int'(mem_en);
        @(posedge clk);
        #1;
        if (w) mem[a] = d;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        mem[a]     = v;
        exp_mem[a] = v;
    endtask

    task automatic check_mem(input string tag);
        int diff = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) diff++;
        check(tag, diff, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " ack"},   {30'd0, if_ack, lsu_ack}, 0);
        check({tag, " mem"},   {29'd0, mem_en, mem_we, busy}, 0);
        check({tag, " addr"},  mem_addr, 0);
        check({tag, " wdata"}, {24'd0, mem_wdata}, 0);
        check({tag, " if_rd"}, if_rdata, 0);
        check({tag, " lsu_rd"}, lsu_rdata, 0);
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Reference: read or write n bytes little-endian at addr (wrapping).
    function automatic logic [31:0] model_access(input logic [31:0] addr, input int n,
                                                 input bit we, input logic [31:0] wd);
        logic [31:0] rd = '0;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            if (we) exp_mem[a[7:0]] = wd[8*i +: 8];
            else    rd |= 32'(exp_mem[a[7:0]]) << (8 * i);
        end
        return rd;
    endfunction

    // Single transaction from IDLE, checking latency, data, pulse width and memory.
    task automatic run_txn(input string tag, input bit is_lsu, input bit we,
                           input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        int          n, m;
        bit          got, other;
        logic [31:0] rd;
        n  = is_lsu ? nbytes(sz) : 4;
        rd = model_access(addr, n, is_lsu && we, wd);
        if (is_lsu) begin
            lsu_req = 1'b1; lsu_we = we; lsu_size = sz; lsu_addr = addr; lsu_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        en_cycles = 0; m = 0; got = 1'b0; other = 1'b0;
        while (!got && m < 20) begin
            step();
            m++;
            got   = is_lsu ? lsu_ack : if_ack;
            other = other | (is_lsu ? if_ack : lsu_ack);
        end
        check({tag, " ack seen"}, got, 1);
        check({tag, " latency"}, m + 1, n + 2);
        check({tag, " mem_en cycles"}, en_cycles, n);
        check({tag, " no stray ack"}, other, 0);
        if (is_lsu && !we) exp_lsu_rd = rd;
        if (!is_lsu)       exp_if_rd  = rd;
        check({tag, " if_rdata"}, if_rdata, exp_if_rd);
        check({tag, " lsu_rdata"}, lsu_rdata, exp_lsu_rd);
        check_mem({tag, " memory"});
        model_last = is_lsu ? LSU : IF;
        lsu_req = 1'b0; if_req = 1'b0;
        step();
        check({tag, " pulse/idle"}, {30'd0, is_lsu ? lsu_ack : if_ack, busy}, 0);
    endtask

    initial begin
        logic        wd;
        logic [1:0]  rsz;
        logic [31:0] raddr, rdata_w, rd;
        owner_t      exp_owner, seen;
        int          m, z_if_cnt, z_lsu_cnt;
        bit          got;

        rst = 1'b0;
        if_req = 0; if_addr = 0; lsu_req = 0; lsu_we = 0; lsu_size = 0; lsu_addr = 0; lsu_wdata = 0;
        z_if_req = 0; z_lsu_req = 0;
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        model_last = LSU; exp_if_rd = 0; exp_lsu_rd = 0; en_cycles = 0;
        #2;
        check_outputs_zero("reset");
        step(); step();
        rst = 1'b1;
        step();

        // Fetch word at 0
        poke(8'd0, 8'h23); poke(8'd1, 8'h81); poke(8'd2, 8'h00); poke(8'd3, 8'h00);
        run_txn("fetch0", 1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
        check("fetch0 value", if_rdata, 32'h0000_8123);

        // LSU word store of 42 at 42
        run_txn("store42", 1'b1, 1'b1, 2'b10, 32'd42, 32'd42);
        check("store42 bytes", {mem[42], mem[43], mem[44], mem[45]}, 32'h2A00_0000);

        // Contention with FAIR=1: both held, grants must alternate
        if_req = 1'b1; if_addr = 32'd0;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'b10; lsu_addr = 32'd4;
        for (int g = 0; g < 4; g++) begin
            exp_owner = (model_last == LSU) ? IF : LSU;
            m = 0; got = 1'b0;
            while (!got && m < 12) begin
                step(); m++;
                got = if_ack || lsu_ack;
            end
            check("contend ack seen", got, 1);
            check("contend one ack", if_ack && lsu_ack, 0);
            seen = if_ack ? IF : LSU;
            check("contend grant order", 32'(seen), 32'(exp_owner));
            rd = model_access((seen == IF) ? 32'd0 : 32'd4, 4, 1'b0, 32'd0);
            if (seen == IF) exp_if_rd = rd; else exp_lsu_rd = rd;
            check("contend if_rdata", if_rdata, exp_if_rd);
            check("contend lsu_rdata", lsu_rdata, exp_lsu_rd);
            model_last = seen;
        end
        if_req = 1'b0; lsu_req = 1'b0;
        step();

        // Half load wrapping from all-ones to 0
        poke(8'hFF, 8'hAB); poke(8'h00, 8'hCD);
        run_txn("wrap", 1'b1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'd0);
        check("wrap value", lsu_rdata, 32'h0000_CDAB);

        // Byte load, zero-extended
        poke(8'd5, 8'h80);
        run_txn("byte5", 1'b1, 1'b0, 2'b00, 32'd5, 32'hFFFF_FFFF);
        check("byte5 value", lsu_rdata, 32'h0000_0080);

        // Random single transactions
        for (int t = 0; t < 24; t++) begin
            wd      = 1'($urandom);
            rsz     = 2'($urandom_range(0, 3));
            raddr   = $urandom;
            rdata_w = $urandom;
            if ($urandom_range(0, 2) == 0) run_txn("rand fetch", 1'b0, 1'b0, 2'b10, raddr, 32'd0);
            else                           run_txn("rand lsu", 1'b1, wd, rsz, raddr, rdata_w);
        end

        // Reset in the middle of a word store, after two bytes
        poke(8'd100, 8'h11); poke(8'd101, 8'h22); poke(8'd102, 8'h33); poke(8'd103, 8'h44);
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 2'b10; lsu_addr = 32'd100; lsu_wdata = 32'hDEAD_BEEF;
        step(); step(); step();
        check("mid-store busy", {busy, mem_we}, 2'b11);
        rst = 1'b0;
        #1;
        check_outputs_zero("async reset");
        exp_mem[100] = 8'hEF; exp_mem[101] = 8'hBE;
        model_last = LSU; exp_if_rd = 0; exp_lsu_rd = 0;
        lsu_req = 1'b0; lsu_we = 1'b0;
        step(); step();
        check("reset no ack", {if_ack, lsu_ack}, 0);
        check_mem("reset partial store");
        rst = 1'b1;
        step();
        run_txn("post-reset fetch", 1'b0, 1'b0, 2'b10, 32'd100, 32'd0);

        // FAIR=0 instance: LSU wins every tie while it keeps requesting
        z_if_req = 1'b1; z_lsu_req = 1'b1;
        z_if_cnt = 0; z_lsu_cnt = 0; m = 0;
        while (z_lsu_cnt < 3 && m < 40) begin
            step(); m++;
            z_if_cnt  += int'(z_if_ack);
            z_lsu_cnt += int'(z_lsu_ack);
        end
        check("nofair lsu acks", z_lsu_cnt, 3);
        check("nofair if starved", z_if_cnt, 0);
        check("nofair lsu_rdata", z_lsu_rdata, 32'h0706_0504);
        z_lsu_req = 1'b0;
        m = 0; got = 1'b0;
        while (!got && m < 12) begin
            step(); m++;
            got = z_if_ack;
        end
        check("nofair if ack seen", got, 1);
        check("nofair if_rdata", z_if_rdata, 32'h0302_0100);
        z_if_req = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
